// File: rtl/bnn_pkg.sv
// Shared defaults and helpers for the binarised conv stream.
package bnn_pkg;

  localparam int unsigned DEF_IMG_W  = 28;
  localparam int unsigned DEF_IMG_H  = 28;
  localparam int unsigned DEF_K      = 5;
  localparam int unsigned DEF_OUT_CH = 18;
  localparam int unsigned DEF_KPC    = 5;
  localparam int unsigned DEF_BW     = 8;

  // Widest window the popcount helper handles.
  localparam int unsigned POP_W = 64;

  localparam int unsigned SUM_W = $clog2(DEF_KPC * DEF_K * DEF_K + 1);

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < int'(POP_W); i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bin_conv_stream_if.sv
// Pixel-in / channel-bits-out stream of the binarised conv layer.
interface bin_conv_stream_if #(
  parameter int unsigned OUT_CH = bnn_pkg::DEF_OUT_CH
);

  logic              in_valid;
  logic              in_ready;
  logic              in_pixel;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_CH-1:0] out_bits;
  logic              out_last;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_bits, out_last
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_bits, out_last
  );

endinterface

// File: rtl/bin_line_buffer.sv
// Column-organised store of the last ROWS image rows; bit ROWS-1 of a column is the oldest row.
module bin_line_buffer #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COL_W = 5
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [COL_W-1:0] col,
  input  logic             din,
  output logic [ROWS-1:0]  col_vec
);

  logic [ROWS-1:0] mem_q [IMG_W];

  assign col_vec = mem_q[col];

  // Shift the newest pixel in at the bottom; the oldest row falls off the top.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[col] <= ROWS'({mem_q[col], din});
    end
  end

endmodule

// File: rtl/bin_conv_stream.sv
// Streaming binarised KxK conv: line buffer + sliding window, XNOR-popcount per channel, threshold.
module bin_conv_stream
  import bnn_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned K      = DEF_K,
  parameter int unsigned OUT_CH = DEF_OUT_CH,
  parameter int unsigned KPC    = DEF_KPC,
  parameter int unsigned bW     = DEF_BW
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [OUT_CH-1:0][KPC-1:0][K-1:0][K-1:0] kernels,
  input  logic [OUT_CH-1:0][bW-1:0]              kernel_offset,
  bin_conv_stream_if.slave                       stream
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned WinW = K * K;
  localparam int unsigned SumW = $clog2(KPC * K * K + 1);
  localparam int unsigned CmpW = (SumW > bW) ? SumW : bW;

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColEdge = ColW'(K - 1);
  localparam logic [RowW-1:0] RowEdge = RowW'(K - 1);

  if (KPC * K * K >= (1 << bW)) begin : g_bad_bw
    $error("bin_conv_stream: KPC*K*K must be below 2**bW");
  end
  if (K < 2 || WinW >= POP_W) begin : g_bad_k
    $error("bin_conv_stream: unsupported kernel size K");
  end

  logic              advance, accept;
  logic [K-2:0]      col_vec;
  logic [K-1:0][K-1:0] win_q;
  logic [ColW-1:0]   col_q;
  logic [RowW-1:0]   row_q;
  logic              v1_q, last1_q;
  logic              out_valid_q, out_last_q;
  logic [OUT_CH-1:0] out_bits_q, bits_d;

  assign advance         = !out_valid_q | stream.out_ready;
  assign accept          = stream.in_valid & advance;
  assign stream.in_ready = advance;
  assign stream.out_valid = out_valid_q;
  assign stream.out_bits  = out_bits_q;
  assign stream.out_last  = out_last_q;

  bin_line_buffer #(
    .IMG_W (IMG_W),
    .ROWS  (K - 1),
    .COL_W (ColW)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (accept),
    .col     (col_q),
    .din     (stream.in_pixel),
    .col_vec (col_vec)
  );

  // Window row 0 is the oldest image row, column 0 the leftmost pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K) - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
      end
      for (int r = 0; r < int'(K) - 1; r++) begin
        win_q[r][K-1] <= col_vec[int'(K) - 2 - r];
      end
      win_q[K-1][K-1] <= stream.in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bits_q  <= '0;
    end else begin
      if (accept) begin
        if (col_q == ColLast) begin
          col_q <= '0;
          row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (advance) begin
        v1_q        <= accept & (row_q >= RowEdge) & (col_q >= ColEdge);
        last1_q     <= accept & (row_q == RowLast) & (col_q == ColLast);
        out_valid_q <= v1_q;
        out_last_q  <= last1_q;
        out_bits_q  <= bits_d;
      end
    end
  end

  for (genvar ch = 0; ch < int'(OUT_CH); ch++) begin : g_ch
    logic [KPC-1:0][WinW-1:0] match;
    logic [SumW-1:0]          sum;

    for (genvar k = 0; k < int'(KPC); k++) begin : g_k
      assign match[k] = ~(win_q ^ kernels[ch][k]);
    end

    always_comb begin
      sum = '0;
      for (int k = 0; k < int'(KPC); k++) begin
        sum = sum + SumW'(popcount({{(POP_W - WinW){1'b0}}, match[k]}));
      end
    end

    assign bits_d[ch] = CmpW'(sum) >= CmpW'(kernel_offset[ch]);
  end

endmodule

// File: tb/tb_bin_conv_stream.sv
// Scoreboard bench for bin_conv_stream: a frame-level reference model feeds an expected queue.
module tb_bin_conv_stream;

  localparam int W   = 28;
  localparam int H   = 28;
  localparam int K   = 5;
  localparam int CH  = 18;
  localparam int KPC = 5;
  localparam int BW  = 8;
  localparam int OH  = H - K + 1;
  localparam int OW  = W - K + 1;

  typedef struct packed {
    logic [CH-1:0] bits;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0][KPC-1:0][K-1:0][K-1:0] kern;
  logic [CH-1:0][BW-1:0]                offs;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   img [H][W];

  always #5 clk = ~clk;

  bin_conv_stream_if #(.OUT_CH(CH)) bus ();

  bin_conv_stream #(
    .IMG_W  (W),
    .IMG_H  (H),
    .K      (K),
    .OUT_CH (CH),
    .KPC    (KPC),
    .bW     (BW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .kernels       (kern),
    .kernel_offset (offs),
    .stream        (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: every window whose completing pixel index is below n_pix, in raster order.
  task automatic push_expected(input int n_pix);
    exp_t e;
    int   s;
    for (int r = 0; r < OH; r++) begin
      for (int c = 0; c < OW; c++) begin
        if ((r + K - 1) * W + (c + K - 1) < n_pix) begin
          for (int ch = 0; ch < CH; ch++) begin
            s = 0;
            for (int k = 0; k < KPC; k++)
              for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                  if (img[r+i][c+j] == kern[ch][k][i][j]) s++;
            e.bits[ch] = (s >= int'(offs[ch]));
          end
          e.last = (r == OH - 1) && (c == OW - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got bits %0h with nothing pending, required none",
                 bus.out_bits);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_bits", 64'(bus.out_bits), 64'(mon_e.bits));
        check("out_last", 64'(bus.out_last), 64'(mon_e.last));
      end
    end
  end

  task automatic send_pixel(input bit p, input bit gaps);
    int n;
    if (gaps && $urandom_range(3) == 0) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_pixel = p;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        check("in_ready_timeout", 64'(0), 64'(1));
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_stall();
    logic [CH-1:0] snap;
    logic          snap_last;
    int            n;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_valid", 64'(bus.out_valid), 64'(1));
    snap      = bus.out_bits;
    snap_last = bus.out_last;
    repeat (10) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'(0));
      check("stall_valid_hold", 64'(bus.out_valid), 64'(1));
      check("stall_bits", 64'(bus.out_bits), 64'(snap));
      check("stall_last", 64'(bus.out_last), 64'(snap_last));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
  endtask

  task automatic send_frame(input int n_pix, input bit gaps, input int stall_at);
    for (int idx = 0; idx < n_pix; idx++) begin
      if (idx == stall_at) do_stall();
      send_pixel(img[idx / W][idx % W], gaps);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_bits", 64'(bus.out_bits), 64'(0));
    check("rst_out_last", 64'(bus.out_last), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_img(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : 1'($urandom_range(1));
  endtask

  task automatic random_kernels();
    for (int ch = 0; ch < CH; ch++)
      for (int k = 0; k < KPC; k++)
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            kern[ch][k][i][j] = 1'($urandom_range(1));
    for (int ch = 0; ch < CH; ch++) offs[ch] = BW'($urandom_range(50, 75));
  endtask

  task automatic run_frame(input bit gaps, input int stall_at);
    push_expected(H * W);
    send_frame(H * W, gaps, stall_at);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pixel  = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    kern          = '0;
    offs          = '0;
    do_reset();

    // All-ones image and kernels: sum 125 everywhere, threshold exactly met then missed.
    fill_img(1);
    kern = '1;
    for (int ch = 0; ch < CH; ch++) offs[ch] = BW'(125);
    run_frame(1'b0, -1);
    for (int ch = 0; ch < CH; ch++) offs[ch] = BW'(126);
    run_frame(1'b0, -1);

    // All-zero kernels: sum 0, even channels offset 0, odd channels offset 1.
    kern = '0;
    for (int ch = 0; ch < CH; ch++) offs[ch] = BW'(ch % 2);
    run_frame(1'b0, -1);

    // Single lit pixel against centre-only kernels on channel 0.
    fill_img(0);
    img[12][12] = 1'b1;
    random_kernels();
    for (int k = 0; k < KPC; k++) begin
      kern[0][k]       = '0;
      kern[0][k][2][2] = 1'b1;
    end
    offs[0] = BW'(125);
    run_frame(1'b1, -1);

    // Random image with input gaps and a mid-frame output stall.
    fill_img(2);
    random_kernels();
    run_frame(1'b1, 300);

    // Abort a frame after 300 pixels, reset, then a full frame.
    fill_img(2);
    random_kernels();
    push_expected(300);
    send_frame(300, 1'b0, -1);
    wait_drain();
    do_reset();
    fill_img(2);
    run_frame(1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
